// File: rtl/pc_unit.sv
// pc_unit: program counter with IDLE/RUN/HALT control, single-step gating,
// hazard stall, jump/branch redirect, sticky misalignment flag and a
// saturating count of PC updates.
module pc_unit #(
  parameter int                      SIZE_ADDR_PC = 32,
  parameter int                      PC_STEP      = 4,
  parameter logic [SIZE_ADDR_PC-1:0] RESET_PC     = '0,
  parameter int                      SIZE_CNT     = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  input  logic                    i_enable,
  input  logic                    i_branch,
  input  logic                    i_jump,
  input  logic [SIZE_ADDR_PC-1:0] i_branch_addr,
  input  logic [SIZE_ADDR_PC-1:0] i_jump_addr,
  input  logic                    i_halt,
  output logic [SIZE_ADDR_PC-1:0] o_PC,
  output logic [SIZE_ADDR_PC-1:0] o_PC_next_seq,
  output logic                    o_running,
  output logic                    o_halted,
  output logic                    o_misaligned,
  output logic [SIZE_CNT-1:0]     o_cycle_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  // PC_STEP is a power of two, so the alignment bits are exactly PC_STEP-1.
  localparam logic [SIZE_ADDR_PC-1:0] STEP       = SIZE_ADDR_PC'(PC_STEP);
  localparam logic [SIZE_ADDR_PC-1:0] ALIGN_MASK = SIZE_ADDR_PC'(PC_STEP - 1);

  state_t                  state, state_nxt;
  logic [SIZE_ADDR_PC-1:0] pc, pc_seq, pc_nxt;
  logic [SIZE_CNT-1:0]     cnt;
  logic                    mis;
  logic                    upd_ok, pc_we, tgt_mis;

  // Update qualification and next-PC selection (jump beats branch beats sequential).
  always_comb begin
    pc_seq  = pc + STEP;  // natural wrap modulo 2^SIZE_ADDR_PC
    upd_ok  = (state == RUN) && i_enable && (!i_step_mode || i_step);
    pc_we   = upd_ok && !i_halt;
    pc_nxt  = pc_seq;
    tgt_mis = 1'b0;
    if (i_jump) begin
      pc_nxt  = i_jump_addr;
      tgt_mis = pc_we && |(i_jump_addr & ALIGN_MASK);
    end else if (i_branch) begin
      pc_nxt  = i_branch_addr;
      tgt_mis = pc_we && |(i_branch_addr & ALIGN_MASK);
    end
  end

  // Control FSM next state; HALT is left only through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (upd_ok && i_halt) state_nxt = HALT;
      default: state_nxt = state;
    endcase
  end

  // State, PC, sticky flag and saturating update counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      cnt   <= '0;
      mis   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pc_we) pc <= pc_nxt;
      if (pc_we && !(&cnt)) cnt <= cnt + SIZE_CNT'(1);
      if (tgt_mis) mis <= 1'b1;
    end
  end

  assign o_PC          = pc;
  assign o_PC_next_seq = pc_seq;
  assign o_running     = (state == RUN);
  assign o_halted      = (state == HALT);
  assign o_misaligned  = mis;
  assign o_cycle_count = cnt;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with hand-computed expectations pushed into a
// scoreboard queue; a monitor pops and compares after each clock edge.
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit instance (defaults)
  logic        r_reset = 1'b1, r_start = 0, r_sm = 0, r_sp = 0, r_en = 0, r_br = 0, r_jp = 0, r_hl = 0;
  logic [31:0] r_ba = '0, r_ja = '0;
  logic [31:0] r_pc, r_nseq, r_cnt;
  logic        r_run, r_hlt, r_mis;

  pc_unit u_dut32 (
    .i_clk(clk), .i_reset(r_reset), .i_start(r_start), .i_step_mode(r_sm), .i_step(r_sp),
    .i_enable(r_en), .i_branch(r_br), .i_jump(r_jp), .i_branch_addr(r_ba), .i_jump_addr(r_ja),
    .i_halt(r_hl), .o_PC(r_pc), .o_PC_next_seq(r_nseq), .o_running(r_run), .o_halted(r_hlt),
    .o_misaligned(r_mis), .o_cycle_count(r_cnt)
  );

  // 8-bit address, 3-bit counter instance for wrap / saturation corners
  logic       s_reset = 1'b1, s_start = 0, s_sm = 0, s_sp = 0, s_en = 0, s_br = 0, s_jp = 0, s_hl = 0;
  logic [7:0] s_ba = '0, s_ja = '0;
  logic [7:0] s_pc, s_nseq;
  logic [2:0] s_cnt;
  logic       s_run, s_hlt, s_mis;

  pc_unit #(.SIZE_ADDR_PC(8), .SIZE_CNT(3)) u_dut8 (
    .i_clk(clk), .i_reset(s_reset), .i_start(s_start), .i_step_mode(s_sm), .i_step(s_sp),
    .i_enable(s_en), .i_branch(s_br), .i_jump(s_jp), .i_branch_addr(s_ba), .i_jump_addr(s_ja),
    .i_halt(s_hl), .o_PC(s_pc), .o_PC_next_seq(s_nseq), .o_running(s_run), .o_halted(s_hlt),
    .o_misaligned(s_mis), .o_cycle_count(s_cnt)
  );

  // input flag bits for drv()
  localparam logic [7:0] R = 8'h80, S = 8'h40, M = 8'h20, P = 8'h10,
                         E = 8'h08, B = 8'h04, J = 8'h02, H = 8'h01;

  typedef struct {
    int          which;
    string       name;
    int          due;
    logic [31:0] pc;
    logic        run, hlt, mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;

  // Apply one cycle of inputs to the selected instance and queue the state
  // expected right after the next rising edge.
  task automatic drv(input int which, input string nm, input logic [7:0] f,
                     input logic [31:0] ba, input logic [31:0] ja,
                     input logic [31:0] epc, input logic erun, input logic ehlt,
                     input logic emis, input logic [31:0] ecnt);
    exp_t e;
    @(negedge clk);
    if (which == 0) begin
      r_reset = f[7]; r_start = f[6]; r_sm = f[5]; r_sp = f[4];
      r_en = f[3]; r_br = f[2]; r_jp = f[1]; r_hl = f[0];
      r_ba = ba; r_ja = ja;
    end else begin
      s_reset = f[7]; s_start = f[6]; s_sm = f[5]; s_sp = f[4];
      s_en = f[3]; s_br = f[2]; s_jp = f[1]; s_hl = f[0];
      s_ba = ba[7:0]; s_ja = ja[7:0];
    end
    e.which = which; e.name = nm; e.due = cyc + 1;
    e.pc = epc; e.run = erun; e.hlt = ehlt; e.mis = emis; e.cnt = ecnt;
    q.push_back(e);
  endtask

  // Monitor: compare every queued expectation once its edge has passed.
  initial begin : monitor
    exp_t        e;
    logic [31:0] apc, anseq, acnt, enseq;
    logic        arun, ahlt, amis;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.which == 0) begin
          apc = r_pc; anseq = r_nseq; acnt = r_cnt; arun = r_run; ahlt = r_hlt; amis = r_mis;
          enseq = e.pc + 32'd4;
        end else begin
          apc = {24'b0, s_pc}; anseq = {24'b0, s_nseq}; acnt = {29'b0, s_cnt};
          arun = s_run; ahlt = s_hlt; amis = s_mis;
          enseq = (e.pc + 32'd4) & 32'hFF;
        end
        n_cmp++;
        if (apc !== e.pc || anseq !== enseq || acnt !== e.cnt ||
            arun !== e.run || ahlt !== e.hlt || amis !== e.mis) begin
          n_bad++;
          $display("FAIL %s: got pc=%h nseq=%h run=%b hlt=%b mis=%b cnt=%0d, want pc=%h nseq=%h run=%b hlt=%b mis=%b cnt=%0d",
                   e.name, apc, anseq, arun, ahlt, amis, acnt,
                   e.pc, enseq, e.run, e.hlt, e.mis, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    int waitc;
    // ---- 32-bit instance ----
    drv(0, "reset0",          R,       0, 0,        32'h00, 0, 0, 0, 0);
    drv(0, "reset1",          R,       0, 0,        32'h00, 0, 0, 0, 0);
    drv(0, "start_no_update", S|E,     0, 0,        32'h00, 1, 0, 0, 0);
    drv(0, "seq_4",           E,       0, 0,        32'h04, 1, 0, 0, 1);
    drv(0, "seq_8",           E,       0, 0,        32'h08, 1, 0, 0, 2);
    drv(0, "seq_12",          E,       0, 0,        32'h0C, 1, 0, 0, 3);
    drv(0, "reset_mid_run",   R|E|J,   0, 32'h80,   32'h00, 0, 0, 0, 0);
    drv(0, "restart",         S,       0, 0,        32'h00, 1, 0, 0, 0);
    drv(0, "run_4",           E,       0, 0,        32'h04, 1, 0, 0, 1);
    drv(0, "run_8",           E,       0, 0,        32'h08, 1, 0, 0, 2);
    drv(0, "jump_over_branch",E|B|J,   32'h40, 32'h80, 32'h80, 1, 0, 0, 3);
    drv(0, "branch_only",     E|B,     32'h40, 0,   32'h40, 1, 0, 0, 4);
    drv(0, "jump_0x10",       E|J,     0, 32'h10,   32'h10, 1, 0, 0, 5);
    drv(0, "stall_with_jump", J,       0, 32'h80,   32'h10, 1, 0, 0, 5);
    drv(0, "stall_2",         0,       0, 0,        32'h10, 1, 0, 0, 5);
    drv(0, "resume_0x14",     E,       0, 0,        32'h14, 1, 0, 0, 6);
    for (int i = 0; i < 5; i++)
      drv(0, "step_no_pulse", M|E,     0, 0,        32'h14, 1, 0, 0, 6);
    drv(0, "step_pulse",      M|E|P,   0, 0,        32'h18, 1, 0, 0, 7);
    drv(0, "step_after",      M|E,     0, 0,        32'h18, 1, 0, 0, 7);
    drv(0, "step_stalled",    M|P,     0, 0,        32'h18, 1, 0, 0, 7);
    drv(0, "step_not_queued", M|E,     0, 0,        32'h18, 1, 0, 0, 7);
    drv(0, "mode_off_same",   E,       0, 0,        32'h1C, 1, 0, 0, 8);
    drv(0, "run_0x20",        E,       0, 0,        32'h20, 1, 0, 0, 9);
    drv(0, "halt_stalled",    H,       0, 0,        32'h20, 1, 0, 0, 9);
    drv(0, "halt_taken",      E|H,     0, 0,        32'h20, 0, 1, 0, 9);
    drv(0, "halt_hold_start", S|M|P|E, 0, 0,        32'h20, 0, 1, 0, 9);
    drv(0, "halt_hold_jump",  E|J,     0, 32'h80,   32'h20, 0, 1, 0, 9);
    drv(0, "reset_from_halt", R,       0, 0,        32'h00, 0, 0, 0, 0);

    // ---- 8-bit instance ----
    @(negedge clk);
    r_reset = 1'b1; r_start = 0; r_sm = 0; r_sp = 0; r_en = 0; r_br = 0; r_jp = 0; r_hl = 0;
    drv(1, "w_reset",         R,       0, 0,        32'h00, 0, 0, 0, 0);
    drv(1, "w_start",         S,       0, 0,        32'h00, 1, 0, 0, 0);
    drv(1, "w_jump_fc",       E|J,     0, 32'hFC,   32'hFC, 1, 0, 0, 1);
    drv(1, "w_wrap",          E,       0, 0,        32'h00, 1, 0, 0, 2);
    drv(1, "w_mis_not_loaded",B,       32'h03, 0,   32'h00, 1, 0, 0, 2);
    drv(1, "w_jump_misalign", E|J,     0, 32'h06,   32'h06, 1, 0, 1, 3);
    drv(1, "w_mis_sticky",    E,       0, 0,        32'h0A, 1, 0, 1, 4);
    drv(1, "w_cnt5",          E,       0, 0,        32'h0E, 1, 0, 1, 5);
    drv(1, "w_cnt6",          E,       0, 0,        32'h12, 1, 0, 1, 6);
    drv(1, "w_cnt7",          E,       0, 0,        32'h16, 1, 0, 1, 7);
    drv(1, "w_cnt_saturate",  E,       0, 0,        32'h1A, 1, 0, 1, 7);
    drv(1, "w_reset_clears",  R,       0, 0,        32'h00, 0, 0, 0, 0);

    waitc = 0;
    while (q.size() > 0 && waitc < 10) begin
      @(posedge clk);
      waitc++;
    end
    #5;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter SIZE_ADDR_PC, default 32, PC and target width in bits.
REQ-002 SHALL have parameter PC_STEP, default 4, sequential increment in bytes.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have parameter SIZE_CNT, default 32, cycle-counter width.
REQ-005 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_start  input  1  leave IDLE and begin fetching.
REQ-008 SHALL have port i_step_mode  input  1  1 = single-step, 0 = continuous.
REQ-009 SHALL have port i_step  input  1  one-cycle pulse; authorises one PC update in step mode.
REQ-010 SHALL have port i_enable  input  1  0 = hazard stall, PC held.
REQ-011 SHALL have port i_branch  input  1  take i_branch_addr.
REQ-012 SHALL have port i_jump  input  1  take i_jump_addr (J/JAL/JR/JALR, target pre-resolved).
REQ-013 SHALL have port i_branch_addr  input  SIZE_ADDR_PC  branch target.
REQ-014 SHALL have port i_jump_addr  input  SIZE_ADDR_PC  jump target.
REQ-015 SHALL have port i_halt  input  1  fetched instruction is HALT.
REQ-016 SHALL have port o_PC  output  SIZE_ADDR_PC  current fetch address.
REQ-017 SHALL have port o_PC_next_seq  output  SIZE_ADDR_PC  o_PC + PC_STEP (return address for link).
REQ-018 SHALL have port o_running  output  1  FSM in RUN.
REQ-019 SHALL have port o_halted  output  1  FSM in HALT.
REQ-020 SHALL have port o_misaligned  output  1  sticky; a loaded target was not PC_STEP-aligned.
REQ-021 SHALL have port o_cycle_count  output  SIZE_CNT  number of PC updates since reset.

Function
REQ-022 SHALL implement FSM states IDLE, RUN, HALT; IDLE->RUN on i_start; RUN->HALT on i_halt when an update would otherwise be permitted; HALT exits only on reset.
REQ-023 SHALL define update-permitted = state RUN and i_enable and (not i_step_mode or i_step).
REQ-024 SHALL, when update-permitted and not i_halt, load PC with: i_jump_addr if i_jump; else i_branch_addr if i_branch; else PC+PC_STEP. i_jump has priority over i_branch when both are asserted.
REQ-025 SHALL hold PC in IDLE, in HALT, when i_enable=0, and in step mode without i_step; i_step while stalled or not in RUN is discarded, not queued.
REQ-026 SHALL, on i_halt with update permitted, hold PC at the HALT instruction address and enter HALT the next cycle.
REQ-027 SHALL compute PC+PC_STEP modulo 2^SIZE_ADDR_PC; all-ones region wraps to low addresses without error.
REQ-028 SHALL present o_PC and o_PC_next_seq combinationally from the PC register; latency from a qualifying input to the new o_PC is one clock.
REQ-029 SHALL set o_misaligned when a loaded target has nonzero bits below log2(PC_STEP); the target is still loaded unmodified; the flag is cleared only by reset.
REQ-030 SHALL increment o_cycle_count on each cycle the PC register is written, saturating at all-ones.
REQ-031 SHALL allow i_step_mode to change at any cycle; the new mode takes effect the same cycle.

Reset
REQ-032 SHALL, while i_reset=1 at a clock edge: PC=RESET_PC, state=IDLE, o_cycle_count=0, o_misaligned=0, o_running=0, o_halted=0; reset mid-RUN or in HALT behaves identically, with all other inputs ignored.

Verification
REQ-033 SHALL cover sequential run: reset, i_start, i_enable=1 for 3 cycles -> o_PC 0,4,8,12; o_cycle_count=3.
REQ-034 SHALL cover priority: o_PC=8, i_branch=1 (0x40), i_jump=1 (0x80) same cycle -> o_PC=0x80 next cycle; o_misaligned=0.
REQ-035 SHALL cover stall: i_enable=0 for 2 cycles at o_PC=0x10 -> o_PC stays 0x10, count unchanged; resumes at 0x14.
REQ-036 SHALL cover step mode: i_step_mode=1, no i_step 5 cycles -> PC held; single i_step -> exactly one PC+4.
REQ-037 SHALL cover halt: i_halt at o_PC=0x20 -> o_halted=1, o_PC=0x20 held despite i_start/i_step; reset -> o_PC=0, IDLE.
REQ-038 SHALL cover wrap and misalignment: SIZE_ADDR_PC=8, PC=0xFC -> next 0x00; jump to 0x06 -> o_PC=0x06, o_misaligned=1 sticky.
